cic_cfg_master: RTL and testbench
=================================

# cic_cfg_master

Configuration initiator for the multichannel CIC decimation chain. It accepts one configuration word at a time from the host/register side and drives it onto the config port of up to NUM_TARGETS CIC stage blocks (integrator, comb, rate counter). Per target, the config port is isConfig, Data_Config_In, isCOnfigACK and isConfigDone. The block pulses isConfig, holds the word stable, and collects each target's isConfigDone pulse under a timeout. It reports completion or failure back to the host.

## Interface
Parameters:
- NUM_TARGETS, 3: number of CIC stage config ports driven (1..16).
- CIC_CONFIG_DATA_WIDTH, 16: config word width.
- TIMEOUT_CYCLES, 64: maximum WAIT cycles per attempt before timeout (≥8).

Ports:
- CLK  in  1  single clock for everything.
- RST  in  1  asynchronous, active-high reset.
- Cfg_Req  in  1  host request; sampled only while Cfg_Ready=1.
- Cfg_Data  in  CIC_CONFIG_DATA_WIDTH  config word.
- Cfg_Mask  in  NUM_TARGETS  targets to configure.
- Cfg_Ready  out  1  high in IDLE only.
- Cfg_Done  out  1  one-cycle success pulse.
- Cfg_Err  out  1  one-cycle failure pulse.
- Err_Mask  out  NUM_TARGETS  targets missing Done at last failure; held until the next accepted request.
- Ack_Seen  out  NUM_TARGETS  sticky per-target isCOnfigACK observed during current/last transaction.
- isConfig  out  NUM_TARGETS  per-target config request pulse.
- Data_Config_Out  out  CIC_CONFIG_DATA_WIDTH  word to all targets' Data_Config_In.
- isCOnfigACK  in  NUM_TARGETS  per-target ACK level.
- isConfigDone  in  NUM_TARGETS  per-target done pulse.

## Operation
- States: IDLE, PULSE, WAIT, DONE, FAIL.
- IDLE: Cfg_Ready=1. On Cfg_Req=1:
  - latch Cfg_Data into Data_Config_Out and Cfg_Mask into mask_r;
  - clear done_seen, Ack_Seen and Err_Mask;
  - go to PULSE, or to DONE if Cfg_Mask==0, with no isConfig pulse.
- PULSE (1 cycle): isConfig = mask_r, then go to WAIT. isConfig is never high for more than one consecutive cycle, because a target re-enters config if isConfig stays high into its done cycle.
- WAIT:
  - done_seen |= isConfigDone & mask_r, also sampled during the PULSE cycle;
  - Ack_Seen |= isCOnfigACK & mask_r. ACK is status only, since targets drop ACK after their first config; completion never depends on it.
  - When (done_seen | new Done bits) == mask_r, go to DONE.
  - The timer counts WAIT cycles. When it reaches TIMEOUT_CYCLES-1 with targets still missing, go to FAIL, or retry (see Configuration).
- DONE: Cfg_Done=1 for 1 cycle, then IDLE.
- FAIL: Cfg_Err=1 for 1 cycle, Err_Mask = mask_r & ~done_seen, then IDLE.
- Data_Config_Out holds the latched word from PULSE until the next accepted request.
- Done from unmasked targets is ignored. A Done from an already-seen target is harmless.
- Cfg_Req outside IDLE is ignored and not queued.
- Reset values: all outputs 0 except Cfg_Ready=1; state is IDLE.
- Reset mid-transaction aborts immediately with no Cfg_Done or Cfg_Err. Targets finish their own sequence independently.

## Timing
- Cfg_Req sampled at edge 0 → isConfig high in cycle 1.
- With a standard CIC stage target, isConfigDone is high in cycle 4 and Cfg_Done is high in cycle 5. Cfg_Ready is low in cycles 1-5 and high again in cycle 6.
- General rule: Cfg_Done is high in the cycle after the last required Done is sampled.
- Timeout: the first WAIT cycle counts as 0. Cfg_Err is high exactly TIMEOUT_CYCLES+1 cycles after the PULSE cycle when no retry is taken.
- A Done arriving in the same cycle the timer expires counts as success; Done has priority over timeout.

## Configuration
- CIC_CFG_RETRY_EN defined: on the first timeout, go back to PULSE with isConfig = mask_r & ~done_seen and restart the timer. done_seen is kept. A second timeout goes to FAIL.
- CIC_CFG_RETRY_EN not defined: the first timeout goes to FAIL. No retry logic is synthesized.

## Test plan
- Basic config: NUM_TARGETS=3, mask=3'b111, three model targets with standard latency, Cfg_Data=16'h000F, request at edge 0. Required: isConfig=3'b111 for cycle 1 only, Data_Config_Out=16'h000F, Cfg_Done in cycle 5, Ack_Seen=3'b111.
- Reconfig after first config: the targets no longer raise ACK, mask=3'b011. Required: Cfg_Done still occurs, Ack_Seen=3'b000, isConfig[2] stays low.
- Timeout: target 1 never responds, mask=3'b111, TIMEOUT_CYCLES=64, retry off. Required: Cfg_Err one pulse, Err_Mask=3'b010, no Cfg_Done.
- Retry (macro on): target 1 responds only on the second pulse. Required: a second isConfig pulse with value 3'b010, then Cfg_Done, no Cfg_Err.
- Edge cases:
  - mask=0 → Cfg_Done one cycle after the request, with no isConfig.
  - Cfg_Req held during WAIT → no second transaction.
  - RST pulse in WAIT → all outputs reset and Cfg_Ready=1 with no Cfg_Done or Cfg_Err.

Source files
------------

// File: rtl/cic_cfg_master_if.sv
// Host request/status lines plus the shared per-target CIC config bus for cic_cfg_master.
// master = the configuration initiator's view; slave = the host and CIC stage side.
interface cic_cfg_master_if #(
    parameter int NUM_TARGETS           = 3,
    parameter int CIC_CONFIG_DATA_WIDTH = 16
);
    logic                             Cfg_Req;
    logic [CIC_CONFIG_DATA_WIDTH-1:0] Cfg_Data;
    logic [NUM_TARGETS-1:0]           Cfg_Mask;
    logic                             Cfg_Ready;
    logic                             Cfg_Done;
    logic                             Cfg_Err;
    logic [NUM_TARGETS-1:0]           Err_Mask;
    logic [NUM_TARGETS-1:0]           Ack_Seen;
    logic [NUM_TARGETS-1:0]           isConfig;
    logic [CIC_CONFIG_DATA_WIDTH-1:0] Data_Config_Out;
    logic [NUM_TARGETS-1:0]           isCOnfigACK;
    logic [NUM_TARGETS-1:0]           isConfigDone;

    modport master (
        input  Cfg_Req, Cfg_Data, Cfg_Mask, isCOnfigACK, isConfigDone,
        output Cfg_Ready, Cfg_Done, Cfg_Err, Err_Mask, Ack_Seen, isConfig, Data_Config_Out
    );

    modport slave (
        output Cfg_Req, Cfg_Data, Cfg_Mask, isCOnfigACK, isConfigDone,
        input  Cfg_Ready, Cfg_Done, Cfg_Err, Err_Mask, Ack_Seen, isConfig, Data_Config_Out
    );
endinterface

// File: rtl/cic_cfg_master.sv
// Configuration initiator: pulses isConfig to the masked CIC stages and collects their Done under a timeout.
// Optional macro CIC_CFG_RETRY_EN: one re-pulse of the still-missing targets before reporting failure.
module cic_cfg_master #(
    parameter int NUM_TARGETS           = 3,
    parameter int CIC_CONFIG_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES        = 64
) (
    input logic               CLK,
    input logic               RST,
    cic_cfg_master_if.master  bus
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t                           state_q, state_d;
    logic [CIC_CONFIG_DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_TARGETS-1:0]           mask_q, mask_d;
    logic [NUM_TARGETS-1:0]           pulse_q, pulse_d;
    logic [NUM_TARGETS-1:0]           done_seen_q, done_seen_d;
    logic [NUM_TARGETS-1:0]           ack_seen_q, ack_seen_d;
    logic [NUM_TARGETS-1:0]           err_mask_q, err_mask_d;
    logic [TW-1:0]                    timer_q, timer_d;
    logic [NUM_TARGETS-1:0]           done_now;
`ifdef CIC_CFG_RETRY_EN
    logic                             retry_q, retry_d;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            pulse_q     <= '0;
            done_seen_q <= '0;
            ack_seen_q  <= '0;
            err_mask_q  <= '0;
            timer_q     <= '0;
`ifdef CIC_CFG_RETRY_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            pulse_q     <= pulse_d;
            done_seen_q <= done_seen_d;
            ack_seen_q  <= ack_seen_d;
            err_mask_q  <= err_mask_d;
            timer_q     <= timer_d;
`ifdef CIC_CFG_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mask_d      = mask_q;
        pulse_d     = pulse_q;
        done_seen_d = done_seen_q;
        ack_seen_d  = ack_seen_q;
        err_mask_d  = err_mask_q;
        timer_d     = timer_q;
`ifdef CIC_CFG_RETRY_EN
        retry_d     = retry_q;
`endif
        // Done seen this very cycle counts, so it wins over an expiring timer.
        done_now    = done_seen_q | (bus.isConfigDone & mask_q);

        case (state_q)
            S_IDLE: begin
                if (bus.Cfg_Req) begin
                    data_d      = bus.Cfg_Data;
                    mask_d      = bus.Cfg_Mask;
                    pulse_d     = bus.Cfg_Mask;
                    done_seen_d = '0;
                    ack_seen_d  = '0;
                    err_mask_d  = '0;
`ifdef CIC_CFG_RETRY_EN
                    retry_d     = 1'b0;
`endif
                    state_d     = (bus.Cfg_Mask == '0) ? S_DONE : S_PULSE;
                end
            end
            S_PULSE: begin
                done_seen_d = done_now;
                ack_seen_d  = ack_seen_q | (bus.isCOnfigACK & mask_q);
                timer_d     = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                done_seen_d = done_now;
                ack_seen_d  = ack_seen_q | (bus.isCOnfigACK & mask_q);
                timer_d     = timer_q + 1'b1;
                if (done_now == mask_q) begin
                    state_d = S_DONE;
                end else if (timer_q == T_LAST) begin
`ifdef CIC_CFG_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        pulse_d = mask_q & ~done_now;
                        state_d = S_PULSE;
                    end else begin
                        err_mask_d = mask_q & ~done_now;
                        state_d    = S_FAIL;
                    end
`else
                    err_mask_d = mask_q & ~done_now;
                    state_d    = S_FAIL;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // isConfig comes straight from the PULSE state, so it can never stay high two cycles in a row.
    assign bus.Cfg_Ready       = (state_q == S_IDLE);
    assign bus.Cfg_Done        = (state_q == S_DONE);
    assign bus.Cfg_Err         = (state_q == S_FAIL);
    assign bus.isConfig        = (state_q == S_PULSE) ? pulse_q : '0;
    assign bus.Data_Config_Out = data_q;
    assign bus.Ack_Seen        = ack_seen_q;
    assign bus.Err_Mask        = err_mask_q;
endmodule

// File: tb/tb_cic_cfg_master.sv
// Directed bench for cic_cfg_master driving three behavioural CIC stage targets.
// Targets answer isConfig with Done three cycles later and raise ACK only on their first config.
`timescale 1ns/1ps
module tb_cic_cfg_master;
    localparam int N = 3;
    localparam int W = 16;
    localparam int T = 64;
`ifdef CIC_CFG_RETRY_EN
    localparam int ERR_CYCLE     = 2 * T + 3;
    localparam int RETRY_PULSES  = 1;
`else
    localparam int ERR_CYCLE     = T + 2;
    localparam int RETRY_PULSES  = 0;
`endif

    logic CLK = 1'b0;
    logic RST;
    int   n_vec = 0;
    int   n_err = 0;

    // Target behaviour: 0 = normal, 1 = never answers, 2 = answers from its second pulse on.
    int mode       [N] = '{default: 0};
    int prev_mode  [N] = '{default: 0};
    int cnt        [N] = '{default: 0};
    int pulses     [N] = '{default: 0};
    bit respond    [N] = '{default: 1'b0};
    bit configured [N] = '{default: 1'b0};

    cic_cfg_master_if #(.NUM_TARGETS(N), .CIC_CONFIG_DATA_WIDTH(W)) bus ();

    cic_cfg_master #(
        .NUM_TARGETS(N),
        .CIC_CONFIG_DATA_WIDTH(W),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (mode[i] != prev_mode[i]) begin
                pulses[i]    = 0;
                prev_mode[i] = mode[i];
            end
            bus.isConfigDone[i] = 1'b0;
            if (cnt[i] != 0) begin
                cnt[i] = cnt[i] - 1;
                if (cnt[i] == 0 && respond[i]) begin
                    bus.isConfigDone[i] = 1'b1;
                    configured[i]       = 1'b1;
                end
            end
            if (bus.isConfig[i]) begin
                pulses[i]  = pulses[i] + 1;
                cnt[i]     = 3;
                respond[i] = (mode[i] == 0) || (mode[i] == 2 && pulses[i] >= 2);
            end
            bus.isCOnfigACK[i] = (cnt[i] != 0) && !configured[i];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Request at the current negedge, sampled on the next edge; returns in the PULSE cycle.
    task automatic apply_stimulus(input logic [W-1:0] data, input logic [N-1:0] mask);
        bus.Cfg_Data = data;
        bus.Cfg_Mask = mask;
        bus.Cfg_Req  = 1'b1;
        step();
        bus.Cfg_Req  = 1'b0;
    endtask

    initial begin
        int  pcnt;
        int  dcnt;
        int  ecnt;
        int  at;
        int  pat;
        logic [N-1:0] pval;
        logic hi2;

        RST          = 1'b1;
        bus.Cfg_Req  = 1'b0;
        bus.Cfg_Data = '0;
        bus.Cfg_Mask = '0;
        repeat (3) step();
        check_output("rst_ready", 32'(bus.Cfg_Ready), 32'd1);
        check_output("rst_done", 32'(bus.Cfg_Done), 32'd0);
        check_output("rst_err", 32'(bus.Cfg_Err), 32'd0);
        check_output("rst_isconfig", 32'(bus.isConfig), 32'd0);
        check_output("rst_data", 32'(bus.Data_Config_Out), 32'd0);
        check_output("rst_ack_seen", 32'(bus.Ack_Seen), 32'd0);
        check_output("rst_err_mask", 32'(bus.Err_Mask), 32'd0);
        RST = 1'b0;
        step();

        // Basic config: pulse in cycle 1, Done from targets in cycle 4, Cfg_Done in cycle 5.
        apply_stimulus(16'h000F, 3'b111);
        check_output("basic_isconfig_c1", 32'(bus.isConfig), 32'h7);
        check_output("basic_data", 32'(bus.Data_Config_Out), 32'h000F);
        check_output("basic_ready_c1", 32'(bus.Cfg_Ready), 32'd0);
        step();
        check_output("basic_isconfig_c2", 32'(bus.isConfig), 32'h0);
        step();
        check_output("basic_done_c3", 32'(bus.Cfg_Done), 32'd0);
        step();
        check_output("basic_done_c4", 32'(bus.Cfg_Done), 32'd0);
        step();
        check_output("basic_done_c5", 32'(bus.Cfg_Done), 32'd1);
        check_output("basic_ready_c5", 32'(bus.Cfg_Ready), 32'd0);
        check_output("basic_ack_seen", 32'(bus.Ack_Seen), 32'h7);
        step();
        check_output("basic_ready_c6", 32'(bus.Cfg_Ready), 32'd1);
        check_output("basic_done_c6", 32'(bus.Cfg_Done), 32'd0);

        // Reconfig: targets no longer ACK, target 2 is masked out.
        apply_stimulus(16'h1234, 3'b011);
        check_output("reconf_isconfig_c1", 32'(bus.isConfig), 32'h3);
        hi2 = bus.isConfig[2];
        repeat (4) begin
            step();
            hi2 = hi2 | bus.isConfig[2];
        end
        check_output("reconf_done_c5", 32'(bus.Cfg_Done), 32'd1);
        check_output("reconf_ack_seen", 32'(bus.Ack_Seen), 32'h0);
        check_output("reconf_isconfig2", 32'(hi2), 32'd0);
        check_output("reconf_data", 32'(bus.Data_Config_Out), 32'h1234);
        step();

        // Empty mask completes one cycle after the request with no pulse.
        apply_stimulus(16'h5555, 3'b000);
        check_output("mask0_done_c1", 32'(bus.Cfg_Done), 32'd1);
        check_output("mask0_isconfig_c1", 32'(bus.isConfig), 32'h0);
        step();
        check_output("mask0_ready_c2", 32'(bus.Cfg_Ready), 32'd1);
        check_output("mask0_done_c2", 32'(bus.Cfg_Done), 32'd0);

        // Cfg_Req held through WAIT must not start a second transaction.
        bus.Cfg_Data = 16'hAAAA;
        bus.Cfg_Mask = 3'b001;
        bus.Cfg_Req  = 1'b1;
        pcnt = 0;
        dcnt = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (bus.isConfig != '0) pcnt++;
            if (bus.Cfg_Done) dcnt++;
            if (c == 4) bus.Cfg_Req = 1'b0;
        end
        check_output("held_pulses", 32'(pcnt), 32'd1);
        check_output("held_dones", 32'(dcnt), 32'd1);
        check_output("held_data", 32'(bus.Data_Config_Out), 32'hAAAA);

        // Reset in WAIT aborts with no completion or error pulse.
        apply_stimulus(16'hBEEF, 3'b111);
        step();
        RST = 1'b1;
        #1;
        check_output("rstwait_ready", 32'(bus.Cfg_Ready), 32'd1);
        check_output("rstwait_data", 32'(bus.Data_Config_Out), 32'd0);
        check_output("rstwait_isconfig", 32'(bus.isConfig), 32'd0);
        step();
        RST  = 1'b0;
        dcnt = 0;
        ecnt = 0;
        repeat (8) begin
            step();
            if (bus.Cfg_Done) dcnt++;
            if (bus.Cfg_Err) ecnt++;
        end
        check_output("rstwait_dones", 32'(dcnt), 32'd0);
        check_output("rstwait_errs", 32'(ecnt), 32'd0);
        check_output("rstwait_ready_end", 32'(bus.Cfg_Ready), 32'd1);

        // Timeout: target 1 never answers.
        mode[1] = 1;
        step();
        apply_stimulus(16'h00C3, 3'b111);
        pcnt = 0;
        dcnt = 0;
        ecnt = 0;
        at   = 0;
        for (int c = 2; c <= ERR_CYCLE + 4; c++) begin
            step();
            if (bus.isConfig != '0) pcnt++;
            if (bus.Cfg_Done) dcnt++;
            if (bus.Cfg_Err) begin
                ecnt++;
                at = c;
            end
        end
        check_output("tmo_err_count", 32'(ecnt), 32'd1);
        check_output("tmo_err_cycle", 32'(at), 32'(ERR_CYCLE));
        check_output("tmo_done_count", 32'(dcnt), 32'd0);
        check_output("tmo_err_mask", 32'(bus.Err_Mask), 32'h2);
        check_output("tmo_retry_pulses", 32'(pcnt), 32'(RETRY_PULSES));
        check_output("tmo_ready_end", 32'(bus.Cfg_Ready), 32'd1);

`ifdef CIC_CFG_RETRY_EN
        // Retry: target 1 answers only its second pulse; the re-pulse carries only its bit.
        mode[1] = 2;
        step();
        apply_stimulus(16'h0F0F, 3'b111);
        dcnt = 0;
        ecnt = 0;
        at   = 0;
        pat  = 0;
        pval = '0;
        for (int c = 2; c <= 80; c++) begin
            step();
            if (bus.isConfig != '0) begin
                pat  = c;
                pval = bus.isConfig;
            end
            if (bus.Cfg_Done) begin
                dcnt++;
                at = c;
            end
            if (bus.Cfg_Err) ecnt++;
        end
        check_output("retry_pulse_cycle", 32'(pat), 32'(T + 2));
        check_output("retry_pulse_value", 32'(pval), 32'h2);
        check_output("retry_done_count", 32'(dcnt), 32'd1);
        check_output("retry_done_cycle", 32'(at), 32'(T + 6));
        check_output("retry_err_count", 32'(ecnt), 32'd0);
        check_output("retry_err_mask", 32'(bus.Err_Mask), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
